// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle multiply/divide unit with HI/LO result registers
//
// Accepts a multiply or divide request in IDLE, stays busy for a fixed
// latency, then writes the result into HI/LO and pulses done for one cycle.
// mthi/mtlo write HI/LO directly from IDLE without entering RUN.
//
// Ports:
//   clk    - single clock, all state updates on the rising edge
//   reset  - synchronous active-high reset
//   start  - request strobe, honoured only in IDLE
//   op     - 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo,
//            110/111 ignored
//   a, b   - operand A (dividend, mthi/mtlo source) and operand B (divisor)
//   busy   - high while an operation is in flight
//   done   - one-cycle pulse when HI/LO take a mult/div result
//   hi, lo - HI/LO result registers

module mult_div_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            done_n;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic            load;

  // Operands latched at acceptance; op_q[1] selects divide, op_q[0] unsigned.
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;

  // Result datapath, evaluated from the latched operands only.
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH-1:0]   quo, rem;
  logic               div_zero;
  logic               div_ovf;

  always_comb begin
    // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the product
    // are then correct for both signed and unsigned interpretations.
    if (op_q[0]) begin
      ext_a = {{WIDTH{1'b0}}, a_q};
      ext_b = {{WIDTH{1'b0}}, b_q};
    end else begin
      ext_a = {{WIDTH{a_q[WIDTH-1]}}, a_q};
      ext_b = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    end
    prod = ext_a * ext_b;
  end

  assign div_zero = (b_q == '0);
  // Signed most-negative / -1 overflows the quotient; it is handled explicitly.
  assign div_ovf  = !op_q[0] && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);

  always_comb begin
    quo = '0;
    rem = '0;
    if (div_zero) begin
      quo = '0;
      rem = '0;
    end else if (div_ovf) begin
      quo = a_q;
      rem = '0;
    end else if (op_q[0]) begin
      quo = a_q / b_q;
      rem = a_q % b_q;
    end else begin
      quo = WIDTH'($signed(a_q) / $signed(b_q));
      rem = WIDTH'($signed(a_q) % $signed(b_q));
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    hi_n    = hi;
    lo_n    = lo;
    load    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          unique case (op)
            OP_MULT, OP_MULTU: begin
              state_n = RUN;
              cnt_n   = CW'(MULT_LAT);
              load    = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              state_n = RUN;
              cnt_n   = CW'(DIV_LAT);
              load    = 1'b1;
            end
            OP_MTHI: hi_n = a;
            OP_MTLO: lo_n = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt <= CW'(1)) begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
          if (!op_q[1]) begin
            hi_n = prod[2*WIDTH-1:WIDTH];
            lo_n = prod[WIDTH-1:0];
          end else if (!div_zero) begin
            hi_n = rem;
            lo_n = quo;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      done  <= done_n;
      hi    <= hi_n;
      lo    <= lo_n;
      if (load) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op[1:0];
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 SHALL have parameter MULT_LAT, default 5, busy cycles for multiply (>=1).
REQ-003 SHALL have parameter DIV_LAT, default 10, busy cycles for divide (>=1).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request strobe, sampled each edge.
REQ-007 SHALL have port op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 reserved.
REQ-008 SHALL have port a  input  WIDTH  operand A / dividend / mthi-mtlo source.
REQ-009 SHALL have port b  input  WIDTH  operand B / divisor.
REQ-010 SHALL have port busy  output  1  operation in flight; new requests refused.
REQ-011 SHALL have port done  output  1  one-cycle pulse when HI/LO take a mult/div result.
REQ-012 SHALL have port hi  output  WIDTH  HI register, registered.
REQ-013 SHALL have port lo  output  WIDTH  LO register, registered.

Function
REQ-014 SHALL implement two states: IDLE (busy=0) and RUN (busy=1), with a down-counter of width ceil(log2(max(MULT_LAT,DIV_LAT)+1)).
REQ-015 SHALL accept a request only when start=1, state=IDLE and reset=0; start while RUN SHALL be ignored entirely, with no queueing.
REQ-016 On accepting op 000-011, SHALL latch a, b and op, enter RUN, load the counter with MULT_LAT or DIV_LAT.
REQ-017 SHALL hold busy=1 for exactly LAT consecutive cycles, starting the cycle after acceptance.
REQ-018 On the edge ending the last RUN cycle, SHALL write HI/LO, return to IDLE and assert done=1 for exactly that one following cycle.
REQ-019 SHALL keep hi/lo at their previous values throughout RUN.
REQ-020 mult/multu: {hi,lo} SHALL equal the full 2*WIDTH signed/unsigned product of the latched operands.
REQ-021 div/divu: lo SHALL be the quotient truncated toward zero and hi the remainder with the sign of the dividend, signed/unsigned respectively.
REQ-022 Signed most-negative / -1: lo SHALL be the most-negative value and hi SHALL be 0.
REQ-023 Divisor zero: SHALL still run DIV_LAT cycles and pulse done, leaving hi/lo unchanged.
REQ-024 mthi/mtlo accepted in IDLE: SHALL write a into hi/lo at that edge, with no RUN state, no busy and no done.
REQ-025 Reserved ops SHALL be ignored, with no state change.
REQ-026 A new request SHALL be acceptable in the same cycle done=1, since state is IDLE.
REQ-027 The result SHALL depend only on operands latched at acceptance; a/b changes during RUN SHALL have no effect.

Reset
REQ-028 With reset=1 at an edge: state->IDLE, counter->0, busy=0, done=0, hi=0, lo=0.
REQ-029 Reset during RUN SHALL abort the operation, with the result discarded and no done pulse afterward.
REQ-030 Reset SHALL take priority over a simultaneous start.

Verification (WIDTH=32, MULT_LAT=5, DIV_LAT=10)
REQ-031 mult a=0xFFFFFFFF b=2 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE, done 1 cycle; multu same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-032 div a=0xFFFFFFF9 (-7) b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu same -> lo=0x7FFFFFFC, hi=0x00000001.
REQ-033 mthi 0x1234 and mtlo 0x5678, then div a=5 b=0 -> busy 10 cycles, done pulses, hi=0x1234, lo=0x5678 unchanged.
REQ-034 div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0; mtlo 0xAAAA issued at busy cycle 4 -> ignored, lo is not 0xAAAA.
REQ-035 mult issued, reset=1 at busy cycle 3 -> next cycle busy=0, hi=lo=0, done never asserts.
REQ-036 multu 3*4 immediately followed by start divu 9/2 in the done cycle -> lo=12 then, 10 cycles later, lo=4, hi=1, with no idle gap.
